uart_tx_fifo: RTL and testbench

Transmit-side buffer that sits directly upstream of the UART transmitter. It accepts bytes from the host side through a write strobe and stores them in a circular FIFO. A drain FSM feeds one byte at a time into the transmitter's load interface (write-enable plus data), paced by the transmitter's holding-empty flag, so the host can queue bursts without polling the serializer.

---
 rtl/uart_tx_fifo_if.sv | 41 ++++
 rtl/uart_tx_fifo.sv | 118 +++++++++++
 tb/tb_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bundles the host push side and the transmitter load side
// of the UART transmit FIFO.
//   host side : i_wr, i_wdata -> FIFO; o_full, o_empty, o_count <- FIFO
//   tx side   : i_tx_mty -> FIFO; o_tx_we, o_tx_data <- FIFO
//   optional  : i_clr_ovf -> FIFO; o_ovf <- FIFO (only with UART_TXF_OVF_EN)
// Modports: master = host/transmitter environment, slave = the FIFO.
interface uart_tx_fifo_if #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  i_wr;
  logic [WIDTH_DATA-1:0] i_wdata;
  logic                  o_full;
  logic                  o_empty;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  i_tx_mty;
  logic                  o_tx_we;
  logic [WIDTH_DATA-1:0] o_tx_data;
`ifdef UART_TXF_OVF_EN
  logic                  o_ovf;
  logic                  i_clr_ovf;

  modport master (
    output i_wr, i_wdata, i_tx_mty, i_clr_ovf,
    input  o_full, o_empty, o_count, o_tx_we, o_tx_data, o_ovf
  );
  modport slave (
    input  i_wr, i_wdata, i_tx_mty, i_clr_ovf,
    output o_full, o_empty, o_count, o_tx_we, o_tx_data, o_ovf
  );
`else
  modport master (
    output i_wr, i_wdata, i_tx_mty,
    input  o_full, o_empty, o_count, o_tx_we, o_tx_data
  );
  modport slave (
    input  i_wr, i_wdata, i_tx_mty,
    output o_full, o_empty, o_count, o_tx_we, o_tx_data
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular FIFO in front of the UART transmitter. The host
// pushes words with i_wr; a 3-state drain FSM hands one word at a time to the
// transmitter (one-cycle o_tx_we with o_tx_data) whenever the transmitter's
// holding register is empty (i_tx_mty).
// Ports:
//   i_clk  : clock, same domain as the transmitter
//   i_nrst : asynchronous active-low reset
//   bus    : uart_tx_fifo_if.slave (host push side + transmitter load side)
// Optional feature macro UART_TXF_OVF_EN: adds sticky overflow flag o_ovf
// (set by a push attempted while full, cleared by i_clr_ovf, set wins).
module uart_tx_fifo #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input logic           i_clk,
  input logic           i_nrst,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_PULSE = 2'd1,
    D_GUARD = 2'd2
  } drain_t;

  drain_t                state, state_n;
  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [PW-1:0]         wptr_n, rptr_n, count_n;
  logic                  full_q, empty_q;
  logic [PW-1:0]         count_q;
  logic                  tx_we_q;
  logic [WIDTH_DATA-1:0] tx_data_q;
  logic                  push, pop;
  logic                  full_n, empty_n;

  // Full is checked against the registered flag only, so a pop in the same
  // cycle never frees a slot for a simultaneous push.
  assign push = bus.i_wr && !full_q;

  // Drain FSM: pop only from D_IDLE; D_PULSE carries the load strobe and
  // D_GUARD gives the transmitter a cycle to drop i_tx_mty.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      D_IDLE: begin
        if (!empty_q && bus.i_tx_mty) begin
          pop     = 1'b1;
          state_n = D_PULSE;
        end
      end
      D_PULSE: state_n = D_GUARD;
      D_GUARD: state_n = D_IDLE;
      default: state_n = D_IDLE;
    endcase
  end

  // Next pointer values; flags are derived from these so they update on the
  // same edge as the pointers. MSB is the wrap bit.
  always_comb begin
    wptr_n  = wptr + {{DEPTH_LOG2{1'b0}}, push};
    rptr_n  = rptr + {{DEPTH_LOG2{1'b0}}, pop};
    count_n = wptr_n - rptr_n;
    empty_n = (wptr_n == rptr_n);
    full_n  = ((wptr_n ^ rptr_n) == {1'b1, {DEPTH_LOG2{1'b0}}});
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= D_IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr      <= '0;
      rptr      <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      count_q   <= '0;
      tx_we_q   <= 1'b0;
      tx_data_q <= '1;
    end else begin
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      full_q  <= full_n;
      empty_q <= empty_n;
      count_q <= count_n;
      tx_we_q <= pop;
      if (pop) tx_data_q <= mem[rptr[DEPTH_LOG2-1:0]];
    end
  end

  // Storage is not reset; stale contents are unreachable after pointer reset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= bus.i_wdata;
  end

`ifdef UART_TXF_OVF_EN
  logic ovf_q;
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)                    ovf_q <= 1'b0;
    else if (bus.i_wr && full_q)    ovf_q <= 1'b1;
    else if (bus.i_clr_ovf)         ovf_q <= 1'b0;
  end
  assign bus.o_ovf = ovf_q;
`endif

  assign bus.o_full    = full_q;
  assign bus.o_empty   = empty_q;
  assign bus.o_count   = count_q;
  assign bus.o_tx_we   = tx_we_q;
  assign bus.o_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus for uart_tx_fifo, checked
// every cycle against a queue-based reference model of the FIFO and its
// load-strobe pacing (one load, then at least two quiet cycles).
module tb_uart_tx_fifo;

  localparam int WD    = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 2 ** DL;

  logic i_clk;
  logic i_nrst;

  uart_tx_fifo_if #(.WIDTH_DATA(WD), .DEPTH_LOG2(DL)) bus ();

  uart_tx_fifo #(.WIDTH_DATA(WD), .DEPTH_LOG2(DL)) dut (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // reference model state
  logic [WD-1:0] q[$];
  int            cool;
  logic [WD-1:0] dexp;
  logic          weexp;
  logic          ovfexp;
  logic [WD-1:0] got[$];
  logic [WD-1:0] sent[$];

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    cool   = 0;
    dexp   = '1;
    weexp  = 1'b0;
    ovfexp = 1'b0;
  endtask

  task automatic check_all();
    chk("count", 32'(bus.o_count), 32'(q.size()));
    chk("full",  32'(bus.o_full),  32'(q.size() == DEPTH));
    chk("empty", 32'(bus.o_empty), 32'(q.size() == 0));
    chk("tx_we", 32'(bus.o_tx_we), 32'(weexp));
    chk("tx_data", 32'(bus.o_tx_data), 32'(dexp));
`ifdef UART_TXF_OVF_EN
    chk("ovf", 32'(bus.o_ovf), 32'(ovfexp));
`endif
    if (bus.o_tx_we === 1'b1) got.push_back(bus.o_tx_data);
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare all outputs shortly after the edge.
  task automatic step();
    bit acc, pp;
    @(posedge i_clk);
    if (!i_nrst) begin
      model_reset();
    end else begin
      pp = 1'b0;
      if (cool > 0) cool--;
      else if (q.size() > 0 && bus.i_tx_mty) pp = 1'b1;
      acc = bus.i_wr && (q.size() < DEPTH);
`ifdef UART_TXF_OVF_EN
      if (bus.i_wr && q.size() == DEPTH) ovfexp = 1'b1;
      else if (bus.i_clr_ovf)            ovfexp = 1'b0;
`endif
      if (pp) begin
        dexp = q.pop_front();
        cool = 2;
      end
      weexp = pp;
      if (acc) q.push_back(bus.i_wdata);
    end
    #1;
    check_all();
  endtask

  task automatic push1(input logic [WD-1:0] d);
    bus.i_wr    = 1'b1;
    bus.i_wdata = d;
    step();
    bus.i_wr    = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (q.size() > 0 || cool > 0); i++) step();
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    bit hit;
    n_chk = 0;
    n_pass = 0;
    bus.i_wr = 1'b0;
    bus.i_wdata = '0;
    bus.i_tx_mty = 1'b1;
`ifdef UART_TXF_OVF_EN
    bus.i_clr_ovf = 1'b0;
`endif
    i_nrst = 1'b0;
    model_reset();
    #12;
    check_all();
    i_nrst = 1'b1;

    // idle after reset: no load strobes
    repeat (5) step();

    // short burst with transmitter always ready
    push1(8'hA5);
    push1(8'h3C);
    push1(8'h81);
    drain(100);

    // fill with transmitter busy, then overflow push
    bus.i_tx_mty = 1'b0;
    got.delete();
    for (int i = 0; i < DEPTH; i++) push1(WD'(i));
    push1(8'hEE);
    chk("fill_count", 32'(bus.o_count), 32'd16);
    chk("fill_full", 32'(bus.o_full), 32'd1);
`ifdef UART_TXF_OVF_EN
    chk("ovf_set", 32'(bus.o_ovf), 32'd1);
    bus.i_clr_ovf = 1'b1;
    step();
    bus.i_clr_ovf = 1'b0;
`endif
    bus.i_tx_mty = 1'b1;
    drain(200);
    chk("fill_order_n", 32'(got.size()), 32'd16);
    for (int i = 0; i < got.size() && i < DEPTH; i++) chk("fill_order", 32'(got[i]), 32'(i));

    // full + simultaneous push/pop: push rejected
    bus.i_tx_mty = 1'b0;
    for (int i = 0; i < DEPTH; i++) push1(WD'(8'h20 + i));
    bus.i_tx_mty = 1'b1;
    push1(8'h77);
    bus.i_tx_mty = 1'b0;
    chk("full_pp_count", 32'(bus.o_count), 32'd15);
    // drain to 8 with the FSM ready to pop, then push and pop together
    bus.i_tx_mty = 1'b1;
    for (int i = 0; i < 200 && !(q.size() == 8 && cool == 0); i++) step();
    chk("reach8", 32'(q.size()), 32'd8);
    push1(8'h99);
    chk("pp8_count", 32'(bus.o_count), 32'd8);
    drain(200);

    // wrap: 40 words, random push and random transmitter readiness
    got.delete();
    sent.delete();
    n = 0;
    for (int c = 0; c < 3000 && n < 40; c++) begin
      bus.i_wr     = 1'($urandom_range(0, 1));
      bus.i_wdata  = WD'($urandom);
      bus.i_tx_mty = 1'($urandom_range(0, 1));
      if (bus.i_wr && q.size() < DEPTH) begin
        sent.push_back(bus.i_wdata);
        n++;
      end
      step();
    end
    bus.i_wr = 1'b0;
    for (int c = 0; c < 3000 && (q.size() > 0 || cool > 0); c++) begin
      bus.i_tx_mty = 1'($urandom_range(0, 1));
      step();
    end
    chk("wrap_n", 32'(got.size()), 32'd40);
    for (int i = 0; i < got.size() && i < sent.size(); i++) chk("wrap_data", 32'(got[i]), 32'(sent[i]));

    // reset mid-drain at count 5
    bus.i_tx_mty = 1'b0;
    for (int i = 0; i < 7; i++) push1(WD'(8'h60 + i));
    bus.i_tx_mty = 1'b1;
    for (int i = 0; i < 100 && q.size() != 5; i++) step();
    chk("reach5", 32'(bus.o_count), 32'd5);
    i_nrst = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    #2;
    i_nrst = 1'b1;
    push1(8'h55);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = (bus.o_tx_we === 1'b1);
    end
    chk("rst_first_we", 32'(hit), 32'd1);
    chk("rst_first_data", 32'(bus.o_tx_data), 32'h55);
    drain(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
